// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster timing from a 50 MHz clock with a 25 MHz pixel enable.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        hs,
  output logic        vs,
  output logic        blank_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        frame_clk,
  output logic        frame_start,
  output logic        pix_en,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counters are 10 bits wide, so neither total may exceed 1024.
  generate
    if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_cfg
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
    end
  endgenerate

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h;
  logic [9:0] v;
  logic       h_wrap;
  logic       frame_wrap;

  always_comb begin
    h_wrap     = (h == H_LAST);
    frame_wrap = pix_en && h_wrap && (v == V_LAST);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_en <= 1'b0;
      h      <= 10'd0;
      v      <= 10'd0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h_wrap) begin
          h <= 10'd0;
          v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
        end else begin
          h <= h + 10'd1;
        end
      end
    end
  end

  // Registered from pre-edge counter values: one Clk behind h/v.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank_n     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      DrawX       <= h;
      DrawY       <= v;
      hs          <= !((h >= HS_START) && (h < HS_END));
      vs          <= !((v >= VS_START) && (v < VS_END));
      blank_n     <= (h < H_VIS) && (v < V_VIS);
      frame_start <= frame_wrap;
    end
  end

  assign frame_clk = vs;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_cnt_q <= 16'd0;
    end else if (frame_start) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - checks vga_timing_gen (standard and shrunk raster) against an arithmetic raster model.
module tb_vga_timing_gen;

  logic        Clk = 1'b0;
  logic        Reset;

  logic        hs, vs, blank_n, frame_clk, frame_start, pix_en;
  logic [9:0]  DrawX, DrawY;
  logic [15:0] frame_count;

  logic        s_hs, s_vs, s_blank_n, s_frame_clk, s_frame_start, s_pix_en;
  logic [9:0]  s_DrawX, s_DrawY;
  logic [15:0] s_frame_count;

  int n      = 0;
  bit in_rst = 1'b0;
  bit valid  = 1'b0;
  int passed = 0;
  int total  = 0;

  always #5 Clk = ~Clk;

  vga_timing_gen dut (
    .Clk(Clk), .Reset(Reset), .hs(hs), .vs(vs), .blank_n(blank_n),
    .DrawX(DrawX), .DrawY(DrawY), .frame_clk(frame_clk),
    .frame_start(frame_start), .pix_en(pix_en), .frame_count(frame_count)
  );

  // Shrunk raster: 16 x 11, so whole frames fit in a short run.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_s (
    .Clk(Clk), .Reset(Reset), .hs(s_hs), .vs(s_vs), .blank_n(s_blank_n),
    .DrawX(s_DrawX), .DrawY(s_DrawY), .frame_clk(s_frame_clk),
    .frame_start(s_frame_start), .pix_en(s_pix_en), .frame_count(s_frame_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s (edge %0d): got %0d expected %0d", name, n, act, exp);
  endtask

  // n = rising edges since Reset was released; pixel index p = (n-1)/2.
  task automatic check_inst(input string tag,
                            input int ha, input int hfp, input int hsw, input int hbp,
                            input int va, input int vfp, input int vsw, input int vbp,
                            input logic a_hs, input logic a_vs, input logic a_fclk,
                            input logic a_bn, input logic [9:0] a_x, input logic [9:0] a_y,
                            input logic a_fs, input logic a_pe, input logic [15:0] a_fc);
    int ht, vt, p, x, y, e_hs, e_vs, e_bn, e_fs, e_pe, e_fc;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    if (in_rst) begin
      x = 0; y = 0; e_hs = 1; e_vs = 1; e_bn = 0; e_fs = 0; e_pe = 0; e_fc = 0;
    end else begin
      p    = (n - 1) / 2;
      x    = p % ht;
      y    = (p / ht) % vt;
      e_hs = (x >= ha + hfp && x < ha + hfp + hsw) ? 0 : 1;
      e_vs = (y >= va + vfp && y < va + vfp + vsw) ? 0 : 1;
      e_bn = (x < ha && y < va) ? 1 : 0;
      e_pe = n % 2;
      e_fs = (n % 2 == 0 && (n / 2) % (ht * vt) == 0) ? 1 : 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
      e_fc = ((n - 1) / (2 * ht * vt)) % 65536;
`else
      e_fc = 0;
`endif
    end
    chk({tag, "DrawX"}, int'(a_x), x);
    chk({tag, "DrawY"}, int'(a_y), y);
    chk({tag, "hs"}, int'(a_hs), e_hs);
    chk({tag, "vs"}, int'(a_vs), e_vs);
    chk({tag, "frame_clk"}, int'(a_fclk), e_vs);
    chk({tag, "blank_n"}, int'(a_bn), e_bn);
    chk({tag, "frame_start"}, int'(a_fs), e_fs);
    chk({tag, "pix_en"}, int'(a_pe), e_pe);
    chk({tag, "frame_count"}, int'(a_fc), e_fc);
  endtask

  always @(posedge Clk) begin
    valid <= 1'b1;
    if (Reset) begin
      n      <= 0;
      in_rst <= 1'b1;
    end else begin
      n      <= n + 1;
      in_rst <= 1'b0;
    end
  end

  always @(negedge Clk) begin
    if (valid) begin
      check_inst("std.", 640, 16, 96, 48, 480, 10, 2, 33,
                 hs, vs, frame_clk, blank_n, DrawX, DrawY, frame_start, pix_en, frame_count);
      check_inst("small.", 8, 2, 3, 3, 6, 1, 2, 2,
                 s_hs, s_vs, s_frame_clk, s_blank_n, s_DrawX, s_DrawY, s_frame_start, s_pix_en,
                 s_frame_count);
      if (!in_rst) begin
        case (n)
          1: begin
            chk("pin_e1_DrawX", int'(DrawX), 0);
            chk("pin_e1_blank_n", int'(blank_n), 1);
            chk("pin_e1_hs", int'(hs), 1);
            chk("pin_e1_vs", int'(vs), 1);
            chk("pin_e1_pix_en", int'(pix_en), 1);
          end
          2: chk("pin_e2_DrawX", int'(DrawX), 0);
          3: chk("pin_e3_DrawX", int'(DrawX), 1);
          1281: chk("pin_blank_at_640", int'(blank_n), 0);
          1312: chk("pin_hs_before_656", int'(hs), 1);
          1313: begin
            chk("pin_DrawX_656", int'(DrawX), 656);
            chk("pin_hs_at_656", int'(hs), 0);
          end
          1504: chk("pin_hs_at_751", int'(hs), 0);
          1505: chk("pin_hs_at_752", int'(hs), 1);
          1600: chk("pin_DrawY_line0_end", int'(DrawY), 0);
          1601: begin
            chk("pin_wrap_DrawX", int'(DrawX), 0);
            chk("pin_wrap_DrawY", int'(DrawY), 1);
          end
          351: chk("pin_small_no_fs", int'(s_frame_start), 0);
          352: chk("pin_small_fs", int'(s_frame_start), 1);
          1057: begin
`ifdef VGA_TIMING_FRAME_CNT_EN
            chk("pin_small_frame_count_3", int'(s_frame_count), 3);
`else
            chk("pin_small_frame_count_0", int'(s_frame_count), 0);
`endif
          end
          default: ;
        endcase
      end
    end
  end

  initial begin
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (3801) @(negedge Clk);
    chk("pin_pre_reset_DrawX", int'(DrawX), 300);
    chk("pin_pre_reset_DrawY", int'(DrawY), 2);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("pin_mid_reset_DrawX", int'(DrawX), 0);
    chk("pin_mid_reset_blank_n", int'(blank_n), 0);
    repeat (500) @(negedge Clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480 @ 60 Hz VGA output path. Derives a 25 MHz pixel enable from the 50 MHz system clock. Runs the horizontal and vertical scan counters and drives the sync, blanking and `DrawX`/`DrawY` coordinates consumed by every sprite and colour block. Also produces `frame_clk`, the per-frame tick those blocks use to update positions.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal front porch / sync width / back porch in pixels
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical front porch / sync width / back porch in lines
- `Clk`  input  1  50 MHz system clock; all logic on rising edge
- `Reset`  input  1  synchronous, active-high reset
- `hs`  output  1  horizontal sync, active low
- `vs`  output  1  vertical sync, active low
- `blank_n`  output  1  high while the pixel is in the visible region
- `DrawX`  output  10  current horizontal counter value (0..H_total-1)
- `DrawY`  output  10  current vertical counter value (0..V_total-1)
- `frame_clk`  output  1  equal to `vs`; rising edge marks the end of vertical sync
- `frame_start`  output  1  one-`Clk` pulse when the raster wraps to (0,0)
- `pix_en`  output  1  pixel-enable phase, high on alternate `Clk` cycles
- `frame_count`  output  16  frame counter (see Configuration)

## Operation
- H_total = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_total = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Both totals must be ≤ 1024. Violating this is a configuration error; flag it at elaboration.
- `pix_en` register toggles every `Clk` and is 0 in reset.
- Internal counters `h` and `v` (10 bits each) advance only on edges where `pix_en` is 1 before the edge.
- `h` wraps from H_total-1 to 0. When it wraps, `v` increments.
- `v` wraps from V_total-1 to 0 on the same edge where `h` wraps at v = V_total-1.
- Outputs are registered from the pre-edge values of `h` and `v`:
  - `DrawX` = h; `DrawY` = v.
  - `hs` = 0 iff H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - `vs` = 0 iff V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (490..491).
  - `blank_n` = (h < H_ACTIVE) && (v < V_ACTIVE).
- `frame_start` is registered 1 for exactly one `Clk` following the edge on which `h` = 799, `v` = 524 and `pix_en` = 1 (the wrap edge). It is 0 otherwise.
- `frame_clk` is the same register as `vs`, not a separate register.
- Reset values: `h` = 0, `v` = 0, `pix_en` = 0, `hs` = 1, `vs` = 1, `frame_clk` = 1, `blank_n` = 0, `DrawX` = 0, `DrawY` = 0, `frame_start` = 0, `frame_count` = 0.
- `Reset` asserted mid-frame: on the next edge all state returns to reset values regardless of `pix_en`. The scan restarts from (0,0) without a `frame_start` pulse.

## Timing
- Each `h` value is held for 2 `Clk`. One line lasts 1600 `Clk`; one frame lasts 840000 `Clk` (59.52 Hz).
- Output latency is 1 `Clk` from the counters. The first edge after `Reset` deasserts gives `DrawX` = 0, `DrawY` = 0, `blank_n` = 1, and `pix_en` = 1.
- `DrawX` is stable for 2 consecutive `Clk` cycles per pixel. Downstream blocks may sample on either cycle.
- `hs` low lasts 192 `Clk` per line. `vs` low lasts 3200 `Clk` per frame.
- `frame_start` and `vs` falling are 490*1600 `Clk` apart within a frame.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined:
  - `frame_count` is a 16-bit register, cleared by `Reset`.
  - It increments on each `Clk` where `frame_start` is 1, so it updates one `Clk` after the pulse.
  - It wraps from 0xFFFF to 0x0000.
- Not defined: `frame_count` is tied to 0 and no counter register is built. All other behaviour is identical.

## Test plan
- Release `Reset` and run 2 `Clk` -> after edge 1: `DrawX` = 0, `DrawY` = 0, `blank_n` = 1, `hs` = 1, `vs` = 1. After edge 2: `DrawX` = 0 still. After edge 3: `DrawX` = 1.
- Run one line -> `hs` falls when `DrawX` becomes 656 and rises when it becomes 752; `blank_n` falls at `DrawX` = 640; `DrawX` wraps 799 -> 0 while `DrawY` goes 0 -> 1.
- Run a full frame -> `vs` is low exactly while `DrawY` ∈ {490, 491}; `frame_start` pulses once, 840000 `Clk` after the first edge post-reset; `blank_n` is 0 for all `DrawY` ≥ 480.
- Assert `Reset` for 1 `Clk` at `DrawX` = 300, `DrawY` = 200 -> next edge shows all outputs at reset values; no `frame_start` pulse; the scan resumes from (0,0).
- With `VGA_TIMING_FRAME_CNT_EN`, run 3 frames -> `frame_count` = 3; force the counter to 0xFFFF then pass one `frame_start` -> 0x0000. Without the macro -> `frame_count` is 0 throughout.
- Sample `DrawX`/`DrawY` on both `pix_en` phases across a line -> identical values within each 2-`Clk` pixel.
